csr_excp_unit: RTL and testbench

CSR_EXCP_UNIT -- requirements
Module: csr_excp_unit

---
 rtl/csr_excp_unit.sv | 190 +++++++++++++++++++
 tb/tb_csr_excp_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_excp_unit.sv
// Exception/interrupt CSR bank: trap entry and return bookkeeping, LL bit,
// registered interrupt-pending flag and a one-cycle fetch redirect.
module csr_excp_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] csr_era,
  input  logic [5:0]  csr_ecode,
  input  logic [8:0]  csr_esubcode,
  input  logic        va_error,
  input  logic [31:0] bad_va,
  input  logic        excp_tlbrefill,
  input  logic        excp_tlb,
  input  logic [18:0] excp_tlb_vppn,
  input  logic        csr_wr_en,
  input  logic [13:0] wr_csr_addr,
  input  logic [31:0] wr_csr_data,
  input  logic        ws_llbit_set,
  input  logic        ws_llbit,
  input  logic [7:0]  hw_int,
  input  logic [13:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        has_int,
  output logic        llbit
);

  localparam logic [13:0] ADDR_CRMD      = 14'h000;
  localparam logic [13:0] ADDR_PRMD      = 14'h001;
  localparam logic [13:0] ADDR_ECFG      = 14'h004;
  localparam logic [13:0] ADDR_ESTAT     = 14'h005;
  localparam logic [13:0] ADDR_ERA       = 14'h006;
  localparam logic [13:0] ADDR_BADV      = 14'h007;
  localparam logic [13:0] ADDR_EENTRY    = 14'h00C;
  localparam logic [13:0] ADDR_TLBEHI    = 14'h011;
  localparam logic [13:0] ADDR_LLBCTL    = 14'h060;
  localparam logic [13:0] ADDR_TLBRENTRY = 14'h088;

  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic        crmd_da;
  logic        crmd_pg;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [9:0]  ecfg_lie;
  logic [1:0]  estat_is_sw;
  logic [7:0]  estat_is_hw;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry_va;
  logic [18:0] tlbehi_vppn;
  logic        llbctl_klo;
  logic [25:0] tlbrentry_pa;

  logic        wr_fire;
  logic        ertn_fire;
  logic [9:0]  estat_is;

  // Flush commits pre-empt software writes; exception pre-empts ertn.
  assign ertn_fire = ertn_flush & ~excp_flush;
  assign wr_fire   = csr_wr_en & ~excp_flush & ~ertn_flush;
  assign estat_is  = {estat_is_hw, estat_is_sw};

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv       <= 2'd0;
      crmd_ie        <= 1'b0;
      crmd_da        <= 1'b1;
      crmd_pg        <= 1'b0;
      prmd_pplv      <= 2'd0;
      prmd_pie       <= 1'b0;
      ecfg_lie       <= 10'd0;
      estat_is_sw    <= 2'd0;
      estat_is_hw    <= 8'd0;
      estat_ecode    <= 6'd0;
      estat_esubcode <= 9'd0;
      era            <= 32'd0;
      badv           <= 32'd0;
      eentry_va      <= 26'd0;
      tlbehi_vppn    <= 19'd0;
      tlbrentry_pa   <= 26'd0;
    end else begin
      estat_is_hw <= hw_int;
      if (excp_flush) begin
        prmd_pplv      <= crmd_plv;
        prmd_pie       <= crmd_ie;
        crmd_plv       <= 2'd0;
        crmd_ie        <= 1'b0;
        era            <= csr_era;
        estat_ecode    <= csr_ecode;
        estat_esubcode <= csr_esubcode;
        if (va_error) badv <= bad_va;
        if (excp_tlb) tlbehi_vppn <= excp_tlb_vppn;
        if (excp_tlbrefill) begin
          crmd_da <= 1'b1;
          crmd_pg <= 1'b0;
        end
      end else if (ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
        // Returning from a TLB refill handler re-enables paged translation.
        if (estat_ecode == 6'h3F) begin
          crmd_da <= 1'b0;
          crmd_pg <= 1'b1;
        end
      end else if (wr_fire) begin
        case (wr_csr_addr)
          ADDR_CRMD: begin
            crmd_plv <= wr_csr_data[1:0];
            crmd_ie  <= wr_csr_data[2];
            crmd_da  <= wr_csr_data[3];
            crmd_pg  <= wr_csr_data[4];
          end
          ADDR_PRMD: begin
            prmd_pplv <= wr_csr_data[1:0];
            prmd_pie  <= wr_csr_data[2];
          end
          ADDR_ECFG:      ecfg_lie     <= wr_csr_data[9:0];
          ADDR_ESTAT:     estat_is_sw  <= wr_csr_data[1:0];
          ADDR_ERA:       era          <= wr_csr_data;
          ADDR_BADV:      badv         <= wr_csr_data;
          ADDR_EENTRY:    eentry_va    <= wr_csr_data[31:6];
          ADDR_TLBEHI:    tlbehi_vppn  <= wr_csr_data[31:13];
          ADDR_TLBRENTRY: tlbrentry_pa <= wr_csr_data[31:6];
          default: ;
        endcase
      end
    end
  end

  // LL bit: the writeback update always wins over WCLLB and the ertn clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      llbit      <= 1'b0;
      llbctl_klo <= 1'b0;
    end else begin
      if (ertn_fire) begin
        if (llbctl_klo) llbctl_klo <= 1'b0;
      end else if (wr_fire && wr_csr_addr == ADDR_LLBCTL) begin
        llbctl_klo <= wr_csr_data[2];
      end

      if (ws_llbit_set) begin
        llbit <= ws_llbit;
      end else if (ertn_fire) begin
        if (!llbctl_klo) llbit <= 1'b0;
      end else if (wr_fire && wr_csr_addr == ADDR_LLBCTL && wr_csr_data[1]) begin
        llbit <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      has_int        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      has_int        <= crmd_ie & (|(estat_is & ecfg_lie));
      redirect_valid <= excp_flush | ertn_flush;
      if (excp_flush) begin
        redirect_pc <= excp_tlbrefill ? {tlbrentry_pa, 6'd0} : {eentry_va, 6'd0};
      end else if (ertn_flush) begin
        redirect_pc <= era;
      end
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      ADDR_CRMD:      rd_data = {27'd0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
      ADDR_PRMD:      rd_data = {29'd0, prmd_pie, prmd_pplv};
      ADDR_ECFG:      rd_data = {22'd0, ecfg_lie};
      ADDR_ESTAT:     rd_data = {1'b0, estat_esubcode, estat_ecode, 6'd0, estat_is};
      ADDR_ERA:       rd_data = era;
      ADDR_BADV:      rd_data = badv;
      ADDR_EENTRY:    rd_data = {eentry_va, 6'd0};
      ADDR_TLBEHI:    rd_data = {tlbehi_vppn, 13'd0};
      ADDR_LLBCTL:    rd_data = {29'd0, llbctl_klo, 1'b0, llbit};
      ADDR_TLBRENTRY: rd_data = {tlbrentry_pa, 6'd0};
      default:        rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_csr_excp_unit.sv
// Bench for csr_excp_unit: whole-word CSR model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_csr_excp_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        excp_flush, ertn_flush;
  logic [31:0] csr_era;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic        va_error;
  logic [31:0] bad_va;
  logic        excp_tlbrefill, excp_tlb;
  logic [18:0] excp_tlb_vppn;
  logic        csr_wr_en;
  logic [13:0] wr_csr_addr;
  logic [31:0] wr_csr_data;
  logic        ws_llbit_set, ws_llbit;
  logic [7:0]  hw_int;
  logic [13:0] rd_addr;
  logic [31:0] rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        has_int;
  logic        llbit;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  csr_excp_unit dut (
    .clk(clk), .reset(reset), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .csr_era(csr_era), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
    .va_error(va_error), .bad_va(bad_va), .excp_tlbrefill(excp_tlbrefill),
    .excp_tlb(excp_tlb), .excp_tlb_vppn(excp_tlb_vppn), .csr_wr_en(csr_wr_en),
    .wr_csr_addr(wr_csr_addr), .wr_csr_data(wr_csr_data),
    .ws_llbit_set(ws_llbit_set), .ws_llbit(ws_llbit), .hw_int(hw_int),
    .rd_addr(rd_addr), .rd_data(rd_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .has_int(has_int), .llbit(llbit)
  );

  always #50 clk = ~clk;

  // Model keeps each CSR as the full 32-bit word software would read back.
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv;
  logic [31:0] m_eentry, m_tlbehi, m_tlbrentry, m_rpc;
  logic        m_klo, m_llbit, m_has_int, m_rv;

  function automatic logic [31:0] model_read(input logic [13:0] a);
    case (a)
      14'h000: return m_crmd;
      14'h001: return m_prmd;
      14'h004: return m_ecfg;
      14'h005: return m_estat;
      14'h006: return m_era;
      14'h007: return m_badv;
      14'h00C: return m_eentry;
      14'h011: return m_tlbehi;
      14'h060: return {29'd0, m_klo, 1'b0, m_llbit};
      14'h088: return m_tlbrentry;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_crmd <= 32'h8;  m_prmd <= 0; m_ecfg <= 0; m_estat <= 0; m_era <= 0;
      m_badv <= 0; m_eentry <= 0; m_tlbehi <= 0; m_tlbrentry <= 0;
      m_klo <= 0; m_llbit <= 0; m_has_int <= 0; m_rv <= 0; m_rpc <= 0;
    end else begin
      m_estat[9:2] <= hw_int;
      m_has_int    <= m_crmd[2] && ((m_estat[9:0] & m_ecfg[9:0]) != 0);
      m_rv         <= excp_flush || ertn_flush;
      if (excp_flush) begin
        m_rpc         <= excp_tlbrefill ? m_tlbrentry : m_eentry;
        m_prmd        <= {29'd0, m_crmd[2:0]};
        m_crmd[2:0]   <= 3'd0;
        if (excp_tlbrefill) m_crmd[4:3] <= 2'b01;
        m_era         <= csr_era;
        m_estat[21:16] <= csr_ecode;
        m_estat[30:22] <= csr_esubcode;
        if (va_error) m_badv <= bad_va;
        if (excp_tlb) m_tlbehi <= {excp_tlb_vppn, 13'd0};
      end else if (ertn_flush) begin
        m_rpc       <= m_era;
        m_crmd[2:0] <= m_prmd[2:0];
        if (m_estat[21:16] == 6'h3F) m_crmd[4:3] <= 2'b10;
        if (m_klo) m_klo <= 1'b0;
        else m_llbit <= 1'b0;
      end else if (csr_wr_en) begin
        case (wr_csr_addr)
          14'h000: m_crmd <= wr_csr_data & 32'h1F;
          14'h001: m_prmd <= wr_csr_data & 32'h7;
          14'h004: m_ecfg <= wr_csr_data & 32'h3FF;
          14'h005: m_estat[1:0] <= wr_csr_data[1:0];
          14'h006: m_era <= wr_csr_data;
          14'h007: m_badv <= wr_csr_data;
          14'h00C: m_eentry <= wr_csr_data & 32'hFFFF_FFC0;
          14'h011: m_tlbehi <= wr_csr_data & 32'hFFFF_E000;
          14'h060: begin
            m_klo <= wr_csr_data[2];
            if (wr_csr_data[1]) m_llbit <= 1'b0;
          end
          14'h088: m_tlbrentry <= wr_csr_data & 32'hFFFF_FFC0;
          default: ;
        endcase
      end
      if (ws_llbit_set) m_llbit <= ws_llbit;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_rd_data", rd_data, model_read(rd_addr));
      checkOutput("cmp_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
      if (m_rv) checkOutput("cmp_redirect_pc", redirect_pc, m_rpc);
      checkOutput("cmp_has_int", {31'd0, has_int}, {31'd0, m_has_int});
      checkOutput("cmp_llbit", {31'd0, llbit}, {31'd0, m_llbit});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of flush/write strobes, then drops them.
  task automatic applyStimulus(input logic ex, input logic er, input logic wr,
                               input logic [13:0] a, input logic [31:0] d);
    excp_flush = ex; ertn_flush = er; csr_wr_en = wr;
    wr_csr_addr = a; wr_csr_data = d;
    tick();
    excp_flush = 1'b0; ertn_flush = 1'b0; csr_wr_en = 1'b0;
  endtask

  task automatic checkRead(input string name, input logic [13:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    checkOutput(name, rd_data, exp);
  endtask

  initial begin
    reset = 1'b1; excp_flush = 0; ertn_flush = 0; csr_era = 0; csr_ecode = 0;
    csr_esubcode = 0; va_error = 0; bad_va = 0; excp_tlbrefill = 0; excp_tlb = 0;
    excp_tlb_vppn = 0; csr_wr_en = 0; wr_csr_addr = 0; wr_csr_data = 0;
    ws_llbit_set = 0; ws_llbit = 0; hw_int = 0; rd_addr = 0;
    tick(); tick();
    reset = 1'b0;
    cmp_en = 1'b1;

    checkRead("reset_crmd", 14'h0, 32'h8);
    checkRead("reset_era", 14'h6, 32'h0);
    checkOutput("reset_redirect", {31'd0, redirect_valid}, 32'd0);
    checkOutput("reset_llbit", {31'd0, llbit}, 32'd0);

    // Ordinary exception entry through EENTRY
    applyStimulus(0, 0, 1, 14'h00C, 32'h1C00_8000);
    applyStimulus(0, 0, 1, 14'h000, 32'h7);
    csr_ecode = 6'h0B; csr_era = 32'h1C00_0100;
    applyStimulus(1, 0, 0, 14'h0, 32'h0);
    checkOutput("excp_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("excp_redirect_pc", redirect_pc, 32'h1C00_8000);
    checkRead("excp_crmd", 14'h0, 32'h0);
    checkRead("excp_prmd", 14'h1, 32'h7);
    checkRead("excp_era", 14'h6, 32'h1C00_0100);
    checkRead("excp_estat", 14'h5, 32'h000B_0000);
    tick();
    checkOutput("excp_redirect_one_cycle", {31'd0, redirect_valid}, 32'd0);

    // TLB refill entry then ertn back to paged mode
    applyStimulus(0, 0, 1, 14'h088, 32'h0000_2000);
    excp_tlbrefill = 1; csr_ecode = 6'h3F; bad_va = 32'h8000_4123; va_error = 1;
    excp_tlb = 1; excp_tlb_vppn = 19'h40002; csr_era = 32'h1C00_0200;
    applyStimulus(1, 0, 0, 14'h0, 32'h0);
    excp_tlbrefill = 0; va_error = 0; excp_tlb = 0;
    checkOutput("refill_redirect_pc", redirect_pc, 32'h0000_2000);
    checkRead("refill_crmd", 14'h0, 32'h8);
    checkRead("refill_badv", 14'h7, 32'h8000_4123);
    checkRead("refill_tlbehi", 14'h11, 32'h8000_4000);
    applyStimulus(0, 1, 0, 14'h0, 32'h0);
    checkOutput("ertn_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("ertn_redirect_pc", redirect_pc, 32'h1C00_0200);
    checkRead("ertn_crmd", 14'h0, 32'h10);

    // Exception beats a same-cycle software write
    csr_era = 32'h100; csr_ecode = 6'h05;
    applyStimulus(1, 0, 1, 14'h006, 32'hDEAD_0000);
    checkRead("excp_over_write_era", 14'h6, 32'h100);
    checkOutput("excp_over_write_pc", redirect_pc, 32'h1C00_8000);
    tick();

    // Interrupt pending path
    applyStimulus(0, 0, 1, 14'h004, 32'h4);
    applyStimulus(0, 0, 1, 14'h000, 32'h4);
    hw_int = 8'h01;
    tick(); tick();
    checkOutput("int_assert", {31'd0, has_int}, 32'd1);
    checkRead("int_estat_is", 14'h5, 32'h0005_0004);
    hw_int = 8'h00;
    tick(); tick();
    checkOutput("int_deassert", {31'd0, has_int}, 32'd0);

    // LL bit with KLO and WCLLB
    ws_llbit_set = 1; ws_llbit = 1;
    tick();
    ws_llbit_set = 0;
    checkOutput("llbit_set", {31'd0, llbit}, 32'd1);
    applyStimulus(0, 0, 1, 14'h060, 32'h4);
    checkRead("llbctl_klo", 14'h60, 32'h5);
    applyStimulus(0, 1, 0, 14'h0, 32'h0);
    checkRead("ertn_klo_keeps_llbit", 14'h60, 32'h1);
    applyStimulus(0, 1, 0, 14'h0, 32'h0);
    checkRead("ertn_clears_llbit", 14'h60, 32'h0);
    ws_llbit_set = 1; ws_llbit = 1;
    applyStimulus(0, 0, 1, 14'h060, 32'h2);
    ws_llbit_set = 0;
    checkOutput("ws_over_wcllb", {31'd0, llbit}, 32'd1);
    applyStimulus(0, 0, 1, 14'h060, 32'h2);
    checkOutput("wcllb_clear", {31'd0, llbit}, 32'd0);

    // Unlisted bits and unmapped addresses
    applyStimulus(0, 0, 1, 14'h002, 32'hFFFF_FFFF);
    checkRead("unmapped_read", 14'h2, 32'h0);
    applyStimulus(0, 0, 1, 14'h000, 32'hFFFF_FFFF);
    checkRead("crmd_mask", 14'h0, 32'h1F);

    // Reset in the flush cycle cancels the redirect
    reset = 1'b1;
    applyStimulus(1, 0, 0, 14'h0, 32'h0);
    reset = 1'b0;
    checkOutput("reset_cancels_redirect", {31'd0, redirect_valid}, 32'd0);
    checkRead("reset_crmd_again", 14'h0, 32'h8);
    tick(); tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
